// File: rtl/q_cycle_sequencer_pkg.sv
// Shared encodings for the instruction-cycle sequencer: Q phases, cycle modes
// and the Q4 strobe bundle. The decoder and bench import the same definitions.
`timescale 1ns/1ps
package q_cycle_sequencer_pkg;

    typedef enum logic [1:0] {
        Q1 = 2'd0,
        Q2 = 2'd1,
        Q3 = 2'd2,
        Q4 = 2'd3
    } q_phase_e;

    typedef enum logic [1:0] {
        MODE_EXEC      = 2'd0,
        MODE_FLUSH     = 2'd1,
        MODE_SLEEP     = 2'd2,
        MODE_WAKE_WAIT = 2'd3
    } cycle_mode_e;

    localparam int unsigned WAKE_CNT_W = 4;

    typedef struct packed {
        logic instr_rd_en;
        logic instr_flush;
        logic pc_incr_en;
        logic pc_j_en;
        logic regfile_wr_en;
        logic w_reg_wr_en;
        logic alu_status_wr_en;
    } strobes_t;

    // Q1 -> Q2 -> Q3 -> Q4 -> Q1 wraps naturally in two bits.
    function automatic q_phase_e next_phase(input q_phase_e ph);
        return q_phase_e'(ph + 2'd1);
    endfunction

endpackage

// File: rtl/q_cycle_sequencer.sv
// Q-phase generator, cycle-mode FSM and wake-delay counter. Decides when the
// fetch/flush/PC/write strobes fire; the decoder supplies what class they are.
`timescale 1ns/1ps
module q_cycle_sequencer
    import q_cycle_sequencer_pkg::*;
#(
    // Whole idle instruction cycles between wake and resumption, 0..15.
    parameter int unsigned WAKE_DELAY_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_en,
    input  logic       cls_write_f,
    input  logic       cls_write_w,
    input  logic       cls_status_wr,
    input  logic       cls_jump,
    input  logic       cls_skip,
    input  logic       skip_cond,
    input  logic       cls_sleep,
    input  logic       wake,
    output logic [1:0] q_phase,
    output logic [1:0] cycle_kind,
    output logic       instr_rd_en,
    output logic       instr_flush,
    output logic       pc_incr_en,
    output logic       pc_j_en,
    output logic       regfile_wr_en,
    output logic       w_reg_wr_en,
    output logic       alu_status_wr_en,
    output logic       sleeping
);

    localparam logic [WAKE_CNT_W-1:0] WAKE_LOAD   = WAKE_CNT_W'(WAKE_DELAY_CYCLES);
    localparam logic                  WAKE_BYPASS = (WAKE_DELAY_CYCLES == 32'd0);

    q_phase_e                phase_r, phase_nxt_s;
    cycle_mode_e             mode_r, mode_nxt_s;
    logic [WAKE_CNT_W-1:0]   wake_cnt_r, wake_cnt_nxt_s;
    strobes_t                strb_s;

    // State register: reset lands on Q1 of a FLUSH cycle so the first fetch primes the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r    <= Q1;
            mode_r     <= MODE_FLUSH;
            wake_cnt_r <= 4'd0;
        end else begin
            phase_r    <= phase_nxt_s;
            mode_r     <= mode_nxt_s;
            wake_cnt_r <= wake_cnt_nxt_s;
        end
    end

    // Next-state logic: run_en=0 freezes everything; mode changes only at Q4 or on wake.
    always_comb begin
        phase_nxt_s    = phase_r;
        mode_nxt_s     = mode_r;
        wake_cnt_nxt_s = wake_cnt_r;
        if (run_en) begin
            case (mode_r)
                MODE_EXEC: begin
                    phase_nxt_s = next_phase(phase_r);
                    if (phase_r == Q4) begin
                        if (cls_jump) begin
                            mode_nxt_s = MODE_FLUSH;
                        end else if (cls_skip && skip_cond) begin
                            mode_nxt_s = MODE_FLUSH;
                        end else if (cls_sleep) begin
                            mode_nxt_s = MODE_SLEEP;
                        end else begin
                            mode_nxt_s = MODE_EXEC;
                        end
                    end else begin
                        mode_nxt_s = mode_r;
                    end
                end
                MODE_FLUSH: begin
                    phase_nxt_s = next_phase(phase_r);
                    if (phase_r == Q4) begin
                        mode_nxt_s = MODE_EXEC;
                    end else begin
                        mode_nxt_s = mode_r;
                    end
                end
                MODE_SLEEP: begin
                    phase_nxt_s = Q1;
                    if (wake) begin
                        if (WAKE_BYPASS) begin
                            mode_nxt_s = MODE_EXEC;
                        end else begin
                            mode_nxt_s     = MODE_WAKE_WAIT;
                            wake_cnt_nxt_s = WAKE_LOAD;
                        end
                    end else begin
                        mode_nxt_s = mode_r;
                    end
                end
                MODE_WAKE_WAIT: begin
                    phase_nxt_s = next_phase(phase_r);
                    // Counter <= 1 also covers a zero count so the wait can never stall.
                    if (phase_r == Q4) begin
                        if (wake_cnt_r <= 4'd1) begin
                            wake_cnt_nxt_s = 4'd0;
                            mode_nxt_s     = MODE_EXEC;
                        end else begin
                            wake_cnt_nxt_s = wake_cnt_r - 4'd1;
                        end
                    end else begin
                        wake_cnt_nxt_s = wake_cnt_r;
                    end
                end
                default: begin
                    phase_nxt_s = phase_r;
                end
            endcase
        end else begin
            phase_nxt_s = phase_r;
        end
    end

    // Strobe decode: everything fires at Q4 only, jump beats skip beats sleep.
    always_comb begin
        strb_s = '0;
        if (run_en && (phase_r == Q4)) begin
            case (mode_r)
                MODE_EXEC: begin
                    strb_s.regfile_wr_en    = cls_write_f;
                    strb_s.w_reg_wr_en      = cls_write_w;
                    strb_s.alu_status_wr_en = cls_status_wr;
                    if (cls_jump) begin
                        strb_s.pc_j_en     = 1'b1;
                        strb_s.instr_flush = 1'b1;
                    end else if (cls_skip && skip_cond) begin
                        strb_s.pc_incr_en  = 1'b1;
                        strb_s.instr_flush = 1'b1;
                    end else begin
                        strb_s.instr_rd_en = 1'b1;
                        strb_s.pc_incr_en  = 1'b1;
                    end
                end
                MODE_FLUSH: begin
                    strb_s.instr_rd_en = 1'b1;
                    strb_s.pc_incr_en  = 1'b1;
                end
                default: begin
                    strb_s = '0;
                end
            endcase
        end else begin
            strb_s = '0;
        end
    end

    assign q_phase          = phase_r;
    assign cycle_kind       = mode_r;
    assign sleeping         = (mode_r == MODE_SLEEP) || (mode_r == MODE_WAKE_WAIT);
    assign instr_rd_en      = strb_s.instr_rd_en;
    assign instr_flush      = strb_s.instr_flush;
    assign pc_incr_en       = strb_s.pc_incr_en;
    assign pc_j_en          = strb_s.pc_j_en;
    assign regfile_wr_en    = strb_s.regfile_wr_en;
    assign w_reg_wr_en      = strb_s.w_reg_wr_en;
    assign alu_status_wr_en = strb_s.alu_status_wr_en;

endmodule

// File: tb/tb_q_cycle_sequencer.sv
// Directed bench for q_cycle_sequencer: two instances (wake delay 2 and 0) share
// stimulus; every clock's expected phase/mode/strobes go through a scoreboard queue.
`timescale 1ns/1ps
module tb_q_cycle_sequencer;
    import q_cycle_sequencer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, run_en, wake;
    logic cls_write_f, cls_write_w, cls_status_wr, cls_jump, cls_skip, skip_cond, cls_sleep;

    logic [1:0] q_phase, cycle_kind, q_phase0, cycle_kind0;
    logic instr_rd_en, instr_flush, pc_incr_en, pc_j_en, regfile_wr_en, w_reg_wr_en, alu_status_wr_en, sleeping;
    logic instr_rd_en0, instr_flush0, pc_incr_en0, pc_j_en0, regfile_wr_en0, w_reg_wr_en0, alu_status_wr_en0, sleeping0;

    q_cycle_sequencer #(.WAKE_DELAY_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .run_en(run_en),
        .cls_write_f(cls_write_f), .cls_write_w(cls_write_w), .cls_status_wr(cls_status_wr),
        .cls_jump(cls_jump), .cls_skip(cls_skip), .skip_cond(skip_cond), .cls_sleep(cls_sleep),
        .wake(wake), .q_phase(q_phase), .cycle_kind(cycle_kind),
        .instr_rd_en(instr_rd_en), .instr_flush(instr_flush), .pc_incr_en(pc_incr_en),
        .pc_j_en(pc_j_en), .regfile_wr_en(regfile_wr_en), .w_reg_wr_en(w_reg_wr_en),
        .alu_status_wr_en(alu_status_wr_en), .sleeping(sleeping)
    );

    q_cycle_sequencer #(.WAKE_DELAY_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .run_en(run_en),
        .cls_write_f(cls_write_f), .cls_write_w(cls_write_w), .cls_status_wr(cls_status_wr),
        .cls_jump(cls_jump), .cls_skip(cls_skip), .skip_cond(skip_cond), .cls_sleep(cls_sleep),
        .wake(wake), .q_phase(q_phase0), .cycle_kind(cycle_kind0),
        .instr_rd_en(instr_rd_en0), .instr_flush(instr_flush0), .pc_incr_en(pc_incr_en0),
        .pc_j_en(pc_j_en0), .regfile_wr_en(regfile_wr_en0), .w_reg_wr_en(w_reg_wr_en0),
        .alu_status_wr_en(alu_status_wr_en0), .sleeping(sleeping0)
    );

    // Strobe bits: {rd, flush, incr, jump, regfile, w, status}
    localparam logic [6:0] S_RD  = 7'b1000000;
    localparam logic [6:0] S_FL  = 7'b0100000;
    localparam logic [6:0] S_INC = 7'b0010000;
    localparam logic [6:0] S_J   = 7'b0001000;
    localparam logic [6:0] S_RF  = 7'b0000100;
    localparam logic [6:0] S_W   = 7'b0000010;
    localparam logic [6:0] S_ST  = 7'b0000001;
    // Class inputs: {write_f, write_w, status_wr, jump, skip, skip_cond, sleep}
    localparam logic [6:0] C_WF  = 7'b1000000;
    localparam logic [6:0] C_WW  = 7'b0100000;
    localparam logic [6:0] C_ST  = 7'b0010000;
    localparam logic [6:0] C_J   = 7'b0001000;
    localparam logic [6:0] C_SK  = 7'b0000100;
    localparam logic [6:0] C_SC  = 7'b0000010;
    localparam logic [6:0] C_SL  = 7'b0000001;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];
    string       tag_q[$];

    wire [11:0] obs_s  = {q_phase, cycle_kind, sleeping, instr_rd_en, instr_flush, pc_incr_en,
                          pc_j_en, regfile_wr_en, w_reg_wr_en, alu_status_wr_en};
    wire [11:0] obs0_s = {q_phase0, cycle_kind0, sleeping0, instr_rd_en0, instr_flush0, pc_incr_en0,
                          pc_j_en0, regfile_wr_en0, w_reg_wr_en0, alu_status_wr_en0};

    task automatic apply_cls(input logic [6:0] cls);
        {cls_write_f, cls_write_w, cls_status_wr, cls_jump, cls_skip, skip_cond, cls_sleep} = cls;
    endtask

    // Queue the expectation, let combinational outputs settle, then pop and compare.
    task automatic check(input bit sel, input string tag, input logic [1:0] ph,
                         input logic [1:0] kind, input logic slp, input logic [6:0] strb);
        logic [11:0] exp_v;
        logic [11:0] got_v;
        string       t;
        exp_q.push_back({ph, kind, slp, strb});
        tag_q.push_back(tag);
        #1;
        got_v = sel ? obs0_s : obs_s;
        exp_v = exp_q.pop_front();
        t     = tag_q.pop_front();
        checks++;
        assert (got_v === exp_v) else begin
            errors++;
            $error("FAIL %s: observed ph/kind/slp/rd,fl,inc,j,rf,w,st=%b required=%b", t, got_v, exp_v);
        end
    endtask

    task automatic run_cycle(input string tag, input logic [1:0] kind,
                             input logic [6:0] cls, input logic [6:0] q4);
        for (int ph = 0; ph < 4; ph++) begin
            @(negedge clk);
            if (ph == 0) apply_cls(cls);
            check(1'b0, tag, ph[1:0], kind, 1'b0, (ph == 3) ? q4 : 7'd0);
        end
    endtask

    task automatic reset_seq(input string tag);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check(1'b0, tag, 2'd0, MODE_FLUSH, 1'b0, 7'd0);
            check(1'b1, tag, 2'd0, MODE_FLUSH, 1'b0, 7'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; run_en = 1'b1; wake = 1'b0;
        apply_cls(7'd0);
        reset_seq("reset");

        // Priming FLUSH, then steady fetch every 4th clk
        run_cycle("first_flush", MODE_FLUSH, 7'd0, S_RD | S_INC);
        for (int i = 0; i < 3; i++) run_cycle("exec_idle", MODE_EXEC, 7'd0, S_RD | S_INC);

        run_cycle("exec_wf_st", MODE_EXEC, C_WF | C_ST, S_RD | S_INC | S_RF | S_ST);
        run_cycle("exec_ww", MODE_EXEC, C_WW, S_RD | S_INC | S_W);

        // Jump: 4 clk jump cycle + 4 clk FLUSH with writes suppressed
        run_cycle("jump", MODE_EXEC, C_J | C_WW, S_J | S_FL | S_W);
        run_cycle("jump_flush", MODE_FLUSH, C_WF | C_ST, S_RD | S_INC);
        run_cycle("after_jump", MODE_EXEC, 7'd0, S_RD | S_INC);

        run_cycle("skip_not_taken", MODE_EXEC, C_SK, S_RD | S_INC);
        run_cycle("after_skip_nt", MODE_EXEC, 7'd0, S_RD | S_INC);
        run_cycle("skip_taken", MODE_EXEC, C_SK | C_SC | C_WF, S_INC | S_FL | S_RF);
        run_cycle("skip_flush", MODE_FLUSH, 7'd0, S_RD | S_INC);
        run_cycle("prio_jump", MODE_EXEC, C_J | C_SK | C_SC | C_SL, S_J | S_FL);
        run_cycle("prio_jump_flush", MODE_FLUSH, 7'd0, S_RD | S_INC);
        run_cycle("prio_skip", MODE_EXEC, C_SK | C_SC | C_SL, S_INC | S_FL);
        run_cycle("prio_skip_flush", MODE_FLUSH, 7'd0, S_RD | S_INC);

        // run_en low for 5 clks at Q2: Q4 strobes land 5 clks late, once
        @(negedge clk); apply_cls(C_WF);
        check(1'b0, "hold_q1", 2'd0, MODE_EXEC, 1'b0, 7'd0);
        @(negedge clk);
        check(1'b0, "hold_q2", 2'd1, MODE_EXEC, 1'b0, 7'd0);
        run_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check(1'b0, "hold_frozen", 2'd1, MODE_EXEC, 1'b0, 7'd0);
        end
        run_en = 1'b1;
        @(negedge clk);
        check(1'b0, "hold_q3", 2'd2, MODE_EXEC, 1'b0, 7'd0);
        @(negedge clk);
        check(1'b0, "hold_q4", 2'd3, MODE_EXEC, 1'b0, S_RD | S_INC | S_RF);
        run_cycle("hold_after", MODE_EXEC, 7'd0, S_RD | S_INC);

        // run_en low while sitting in Q4 masks strobes, then they fire once
        @(negedge clk); apply_cls(C_WW);
        check(1'b0, "q4hold_q1", 2'd0, MODE_EXEC, 1'b0, 7'd0);
        @(negedge clk); check(1'b0, "q4hold_q2", 2'd1, MODE_EXEC, 1'b0, 7'd0);
        @(negedge clk); check(1'b0, "q4hold_q3", 2'd2, MODE_EXEC, 1'b0, 7'd0);
        @(negedge clk); run_en = 1'b0;
        check(1'b0, "q4_frozen", 2'd3, MODE_EXEC, 1'b0, 7'd0);
        @(negedge clk);
        check(1'b0, "q4_frozen2", 2'd3, MODE_EXEC, 1'b0, 7'd0);
        run_en = 1'b1;
        check(1'b0, "q4_resume", 2'd3, MODE_EXEC, 1'b0, S_RD | S_INC | S_W);
        run_cycle("q4_after", MODE_EXEC, 7'd0, S_RD | S_INC);

        // SLEEP with junk class inputs, then wake: delay 2 vs delay 0
        run_cycle("sleep_instr", MODE_EXEC, C_SL, S_RD | S_INC);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) apply_cls(7'h7F);
            if (i == 10) apply_cls(7'd0);
            check(1'b0, "sleep_hold", 2'd0, MODE_SLEEP, 1'b1, 7'd0);
            check(1'b1, "sleep_hold0", 2'd0, MODE_SLEEP, 1'b1, 7'd0);
        end
        @(negedge clk); wake = 1'b1;
        check(1'b0, "sleep_wake", 2'd0, MODE_SLEEP, 1'b1, 7'd0);
        check(1'b1, "sleep_wake0", 2'd0, MODE_SLEEP, 1'b1, 7'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) wake = 1'b0;
            check(1'b0, "wake_wait", 2'(i % 4), MODE_WAKE_WAIT, 1'b1, 7'd0);
            if (i < 4) check(1'b1, "wake0_exec", 2'(i), MODE_EXEC, 1'b0, (i == 3) ? (S_RD | S_INC) : 7'd0);
        end
        run_cycle("wake_resume", MODE_EXEC, C_WW, S_RD | S_INC | S_W);

        reset_seq("reset_resync");
        run_cycle("flush2", MODE_FLUSH, 7'd0, S_RD | S_INC);
        run_cycle("sleep_instr2", MODE_EXEC, C_SL, S_RD | S_INC);
        @(negedge clk);
        check(1'b0, "sleep2", 2'd0, MODE_SLEEP, 1'b1, 7'd0);
        check(1'b1, "sleep2_0", 2'd0, MODE_SLEEP, 1'b1, 7'd0);
        reset_seq("reset_in_sleep");

        // Reset at Q3 of a jump: no pc_j_en, back to Q1/FLUSH
        run_cycle("flush3", MODE_FLUSH, 7'd0, S_RD | S_INC);
        @(negedge clk); apply_cls(C_J);
        check(1'b0, "rstmid_q1", 2'd0, MODE_EXEC, 1'b0, 7'd0);
        @(negedge clk); check(1'b0, "rstmid_q2", 2'd1, MODE_EXEC, 1'b0, 7'd0);
        @(negedge clk); rst = 1'b1;
        check(1'b0, "rstmid_q3", 2'd2, MODE_EXEC, 1'b0, 7'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check(1'b0, "rstmid_held", 2'd0, MODE_FLUSH, 1'b0, 7'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        apply_cls(7'd0);
        run_cycle("rst_flush", MODE_FLUSH, 7'd0, S_RD | S_INC);
        run_cycle("rst_exec", MODE_EXEC, 7'd0, S_RD | S_INC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
